// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the logic gate pipeline: op codes, FSM state encoding
// and the per-bit gate function used by the datapath.
package logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND    = 3'd0;
    localparam op_t OP_OR     = 3'd1;
    localparam op_t OP_XOR    = 3'd2;
    localparam op_t OP_NAND   = 3'd3;
    localparam op_t OP_NOR    = 3'd4;
    localparam op_t OP_XNOR   = 3'd5;
    localparam op_t OP_PASS_A = 3'd6;
    localparam op_t OP_NOT_A  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Single-bit gate; callers apply it across a vector so the package stays width-agnostic.
    function automatic logic gate_bit(input op_t op, input logic p, input logic q);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = p & q;
            OP_OR:     r = p | q;
            OP_XOR:    r = p ^ q;
            OP_NAND:   r = ~(p & q);
            OP_NOR:    r = ~(p | q);
            OP_XNOR:   r = ~(p ^ q);
            OP_PASS_A: r = p;
            default:   r = ~p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Input-beat and output-result handshake bundle for logic_gate_pipe.
// The slave modport is the pipeline side; master is the driver/sink side.
interface logic_gate_pipe_if
    import logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_t              in_op;
    logic             in_accum;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_a, in_b, in_op, in_accum, in_last, out_ready,
        input  in_ready, out_valid, out_x, out_beats
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_accum, in_last, out_ready,
        output in_ready, out_valid, out_x, out_beats
    );

endinterface

// File: rtl/logic_gate_pipe_fifo.sv
// Result FIFO with valid/ready on both sides. Full/empty come from an extra
// pointer bit, so push readiness never depends combinationally on the pop side.
module logic_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  logic [DW-1:0] i_push_data,
    output logic          o_pop_valid,
    input  logic          i_pop_ready,
    output logic [DW-1:0] o_pop_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push_valid && !w_full;
    assign w_pop   = i_pop_ready && !w_empty;

    assign o_push_ready = !w_full;
    assign o_pop_valid  = !w_empty;
    assign o_pop_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit gate with runtime op select, multi-beat reduce bursts
// and an output FIFO carrying {result, beat count}.
module logic_gate_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    logic_gate_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [WIDTH-1:0] gate_vec(input op_t op,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = gate_bit(op, p[i], q[i]);
        return r;
    endfunction

    state_e           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    op_t              r_op_q;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    op_t              w_op_nxt;

    logic             w_fifo_ready;
    logic             w_fire;
    logic [WIDTH-1:0] w_gate_ab;
    logic [WIDTH-1:0] w_gate_acc;
    logic [CNT_W-1:0] w_cnt_sat;

    logic             w_push;
    logic [WIDTH-1:0] w_push_x;
    logic [CNT_W-1:0] w_push_beats;
    logic [WIDTH+CNT_W-1:0] w_pop_data;

    assign bus.in_ready = w_fifo_ready;
    assign w_fire       = bus.in_valid && w_fifo_ready;
    assign w_gate_ab    = gate_vec(bus.in_op, bus.in_a, bus.in_b);
    assign w_gate_acc   = gate_vec(r_op_q, r_acc, bus.in_a);
    assign w_cnt_sat    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op_q;
        w_push       = 1'b0;
        w_push_x     = '0;
        w_push_beats = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (!bus.in_accum || bus.in_last) begin
                        w_push       = 1'b1;
                        w_push_x     = w_gate_ab;
                        w_push_beats = CNT_ONE;
                    end else begin
                        w_acc_nxt   = w_gate_ab;
                        w_op_nxt    = bus.in_op;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                // Continuation beats fold A into the accumulator with the op latched at burst start.
                if (w_fire) begin
                    if (!bus.in_last) begin
                        w_acc_nxt = w_gate_acc;
                        w_cnt_nxt = w_cnt_sat;
                    end else begin
                        w_push       = 1'b1;
                        w_push_x     = w_gate_acc;
                        w_push_beats = w_cnt_sat;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op_q  <= OP_AND;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op_q  <= w_op_nxt;
        end
    end

    logic_fifo #(
        .DW    (WIDTH + CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (w_push),
        .o_push_ready (w_fifo_ready),
        .i_push_data  ({w_push_x, w_push_beats}),
        .o_pop_valid  (bus.out_valid),
        .i_pop_ready  (bus.out_ready),
        .o_pop_data   (w_pop_data)
    );

    assign bus.out_x     = w_pop_data[WIDTH+CNT_W-1:CNT_W];
    assign bus.out_beats = w_pop_data[CNT_W-1:0];

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: a queue-based model checked every cycle on two
// instances (CNT_W=8 and CNT_W=2), plus hand-computed directed expectations.
module tb_logic_gate_pipe;
    import logic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(2)) busc ();

    logic_gate_pipe #(.WIDTH(8), .FIFO_DEPTH(2), .CNT_W(8)) u_dut8 (
        .clk (clk), .rst (rst), .bus (bus8.slave));
    logic_gate_pipe #(.WIDTH(8), .FIFO_DEPTH(2), .CNT_W(2)) u_dutc (
        .clk (clk), .rst (rst), .bus (busc.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] x;
        int         beats;
    } exp_t;

    localparam int DEPTH = 2;
    exp_t       q0[$];
    exp_t       q1[$];
    logic       m_burst [2] = '{1'b0, 1'b0};
    logic [2:0] m_op    [2] = '{3'd0, 3'd0};
    logic [7:0] m_acc   [2] = '{8'h00, 8'h00};
    int         m_cnt   [2] = '{0, 0};
    int         cmax    [2] = '{255, 3};

    function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] p, input logic [7:0] q);
        case (op)
            3'd0:    return p & q;
            3'd1:    return p | q;
            3'd2:    return p ^ q;
            3'd3:    return ~(p & q);
            3'd4:    return ~(p | q);
            3'd5:    return ~(p ^ q);
            3'd6:    return p;
            default: return ~p;
        endcase
    endfunction

    task automatic model_step(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic accum, input logic last,
                              input logic oready);
        int   sz;
        bit   do_pop;
        bit   do_push;
        exp_t e;
        sz      = (d == 0) ? q0.size() : q1.size();
        do_pop  = oready && (sz > 0);
        do_push = 1'b0;
        e.x     = 8'h00;
        e.beats = 0;
        if (v && sz < DEPTH) begin
            if (!m_burst[d]) begin
                if (!accum || last) begin
                    do_push = 1'b1;
                    e.x     = f(op, a, b);
                    e.beats = 1;
                end else begin
                    m_burst[d] = 1'b1;
                    m_op[d]    = op;
                    m_acc[d]   = f(op, a, b);
                    m_cnt[d]   = 1;
                end
            end else begin
                m_acc[d] = f(m_op[d], m_acc[d], a);
                m_cnt[d] = (m_cnt[d] + 1 > cmax[d]) ? cmax[d] : m_cnt[d] + 1;
                if (last) begin
                    do_push    = 1'b1;
                    e.x        = m_acc[d];
                    e.beats    = m_cnt[d];
                    m_burst[d] = 1'b0;
                end
            end
        end
        if (d == 0) begin
            if (do_pop)  void'(q0.pop_front());
            if (do_push) q0.push_back(e);
        end else begin
            if (do_pop)  void'(q1.pop_front());
            if (do_push) q1.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q0.delete();
            q1.delete();
            m_burst = '{1'b0, 1'b0};
            m_cnt   = '{0, 0};
        end else begin
            model_step(0, bus8.in_valid, bus8.in_a, bus8.in_b, bus8.in_op,
                       bus8.in_accum, bus8.in_last, bus8.out_ready);
            model_step(1, busc.in_valid, busc.in_a, busc.in_b, busc.in_op,
                       busc.in_accum, busc.in_last, busc.out_ready);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("d8 out_valid", 32'(bus8.out_valid), 32'(q0.size() > 0));
        check("d8 in_ready", 32'(bus8.in_ready), 32'(q0.size() < DEPTH));
        if (q0.size() > 0) begin
            check("d8 out_x", 32'(bus8.out_x), 32'(q0[0].x));
            check("d8 out_beats", 32'(bus8.out_beats), q0[0].beats);
        end else begin
            check("d8 idle out_x", 32'(bus8.out_x), 32'h0);
            check("d8 idle out_beats", 32'(bus8.out_beats), 32'h0);
        end
        check("dc out_valid", 32'(busc.out_valid), 32'(q1.size() > 0));
        check("dc in_ready", 32'(busc.in_ready), 32'(q1.size() < DEPTH));
        if (q1.size() > 0) begin
            check("dc out_x", 32'(busc.out_x), 32'(q1[0].x));
            check("dc out_beats", 32'(busc.out_beats), q1[0].beats);
        end else begin
            check("dc idle out_x", 32'(busc.out_x), 32'h0);
            check("dc idle out_beats", 32'(busc.out_beats), 32'h0);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic accum, input logic last);
        if (d == 0) begin
            bus8.in_valid = v; bus8.in_a = a; bus8.in_b = b;
            bus8.in_op = op; bus8.in_accum = accum; bus8.in_last = last;
        end else begin
            busc.in_valid = v; busc.in_a = a; busc.in_b = b;
            busc.in_op = op; busc.in_accum = accum; busc.in_last = last;
        end
    endtask

    // Offers one beat, returns #1 after the edge that accepted it.
    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic accum, input logic last);
        bit accepted;
        accepted = 1'b0;
        drive(d, 1'b1, a, b, op, accum, last);
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(posedge clk);
            accepted = (d == 0) ? bus8.in_ready : busc.in_ready;
        end
        #1;
        drive(d, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        if (!accepted) check("accept timeout", 32'h0, 32'h1);
    endtask

    logic [7:0] exp_single [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
    logic [7:0] or_beats   [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

    initial begin
        drive(0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        bus8.out_ready = 1'b1;
        busc.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus8.out_valid), 32'h0);
        check("reset out_x", 32'(bus8.out_x), 32'h0);
        check("reset out_beats", 32'(bus8.out_beats), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 32'(bus8.in_ready), 32'h1);

        // Single mode, every op, one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            send(0, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
            check($sformatf("single op%0d out_x", i), 32'(bus8.out_x), 32'(exp_single[i]));
            check($sformatf("single op%0d beats", i), 32'(bus8.out_beats), 32'h1);
            check($sformatf("single op%0d valid", i), 32'(bus8.out_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        check("single drained", 32'(bus8.out_valid), 32'h0);

        // XOR burst; op and b on continuation beats must be ignored.
        send(0, 8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        check("burst mid1 valid", 32'(bus8.out_valid), 32'h0);
        send(0, 8'h04, 8'hFF, 3'd0, 1'b1, 1'b0);
        check("burst mid2 valid", 32'(bus8.out_valid), 32'h0);
        send(0, 8'h08, 8'hFF, 3'd5, 1'b0, 1'b1);
        check("burst xor out_x", 32'(bus8.out_x), 32'h0F);
        check("burst xor beats", 32'(bus8.out_beats), 32'h3);
        @(posedge clk);
        #1;

        // Backpressure: third single must wait for a pop.
        bus8.out_ready = 1'b0;
        send(0, 8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        check("bp first out_x", 32'(bus8.out_x), 32'h33);
        send(0, 8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0);
        check("bp full in_ready", 32'(bus8.in_ready), 32'h0);
        check("bp hold out_x", 32'(bus8.out_x), 32'h33);
        fork
            send(0, 8'h55, 8'hAA, 3'd2, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp stalled out_x", 32'(bus8.out_x), 32'h33);
                check("bp stalled in_ready", 32'(bus8.in_ready), 32'h0);
                bus8.out_ready = 1'b1;
            end
        join
        check("bp third out_x", 32'(bus8.out_x), 32'hFF);
        check("bp third beats", 32'(bus8.out_beats), 32'h1);

        // One entry queued: push and pop on the same edge.
        send(0, 8'hA5, 8'h0F, 3'd0, 1'b0, 1'b0);
        check("pushpop valid", 32'(bus8.out_valid), 32'h1);
        check("pushpop out_x", 32'(bus8.out_x), 32'h05);
        check("pushpop in_ready", 32'(bus8.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("pushpop drained", 32'(bus8.out_valid), 32'h0);

        // Reset mid-burst with a result waiting in the FIFO.
        bus8.out_ready = 1'b0;
        send(0, 8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
        check("prefill out_x", 32'(bus8.out_x), 32'h36);
        send(0, 8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
        send(0, 8'h3C, 8'h00, 3'd0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(bus8.out_valid), 32'h0);
        check("midrst out_x", 32'(bus8.out_x), 32'h0);
        @(negedge clk) rst = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'hFF, 8'h0F, 3'd1, 1'b0, 1'b0);
        check("after rst out_x", 32'(bus8.out_x), 32'hFF);
        check("after rst beats", 32'(bus8.out_beats), 32'h1);
        @(posedge clk);
        #1;

        // Five-beat OR burst: beat count saturates at 3 when CNT_W=2, reaches 5 when CNT_W=8.
        for (int i = 0; i < 5; i++) begin
            send(1, or_beats[i], 8'h00, 3'd1, 1'b1, (i == 4));
            if (i < 4) check("cnt2 mid valid", 32'(busc.out_valid), 32'h0);
        end
        check("cnt2 out_x", 32'(busc.out_x), 32'h1F);
        check("cnt2 sat beats", 32'(busc.out_beats), 32'h3);
        for (int i = 0; i < 5; i++) send(0, or_beats[i], 8'h00, 3'd1, 1'b1, (i == 4));
        check("cnt8 out_x", 32'(bus8.out_x), 32'h1F);
        check("cnt8 beats", 32'(bus8.out_beats), 32'h5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
